shift_operand_decoder: RTL
==========================

SHIFT_OPERAND_DECODER -- requirements
Module: shift_operand_decoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: instruction offered.
REQ-004 SHALL have port in_ready, output, 1 bit: decoder accepts the instruction this cycle.
REQ-005 SHALL have port instr, input, 32 bits: data-processing instruction word; operand2 occupies bits [25] and [11:0].
REQ-006 SHALL have port rf_rd_en, output, 1 bit: register-file read request.
REQ-007 SHALL have port rf_rd_addr, output, 4 bits: register index for the read request.
REQ-008 SHALL have port rf_rd_data, input, 32 bits: read data, valid exactly one cycle after rf_rd_en.
REQ-009 SHALL have port out_valid, output, 1 bit: operand bundle valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream barrel shifter consumes the bundle.
REQ-011 SHALL have port shift_in, output, 32 bits: value to be shifted.
REQ-012 SHALL have port shift_op, output, 2 bits: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-013 SHALL have port shift_amt, output, 32 bits: shift distance.
REQ-014 SHALL have port rrx, output, 1 bit: rotate-right-extended request (ROR #0 encoding).

Function
REQ-015 SHALL implement FSM states IDLE, RM, RS, CAP, OUT.
REQ-016 in_ready SHALL equal (state==IDLE) or (state==OUT and out_ready); a handshake SHALL register instr.
REQ-017 Immediate form (instr[25]=1): accept -> OUT; shift_in = zero-extended instr[7:0]; shift_op = 11; shift_amt = 2*instr[11:8]; rrx = 0; out_valid 1 cycle after accept.
REQ-018 Register form (instr[25]=0): accept -> RM; in RM, rf_rd_en=1 with rf_rd_addr=instr[3:0]; next state RS.
REQ-019 In RS, the block SHALL capture rf_rd_data into shift_in; if instr[4]=0, next state OUT (out_valid 3 cycles after accept).
REQ-020 In RS with instr[4]=1, rf_rd_en=1 with rf_rd_addr=instr[11:8]; next state CAP, where rf_rd_data[7:0] zero-extended SHALL become shift_amt; next state OUT (out_valid 4 cycles after accept).
REQ-021 Immediate-shift amount instr[11:7]: LSL #n -> n; LSR #0 and ASR #0 -> 32; ROR #0 -> shift_op=11, shift_amt=1, rrx=1; otherwise n.
REQ-022 Register-shift amount SHALL be passed unmodified, including 0 and values >= 32; rrx=0.
REQ-023 rf_rd_en SHALL be 0 in every state other than RM, and other than RS with instr[4]=1.
REQ-024 In OUT, out_valid=1; shift_in, shift_op, shift_amt and rrx SHALL hold stable while out_ready=0.
REQ-025 OUT with out_ready=1 and in_valid=1 SHALL accept the next instruction in the same cycle (back-to-back); with in_valid=0, next state IDLE.
REQ-026 Reads of index 15 SHALL be issued like any other register; PC substitution is out of scope.

Reset
REQ-027 While rst_n=0: state=IDLE; out_valid, rf_rd_en, rrx = 0; shift_in, shift_amt = 0; shift_op = 00; rf_rd_addr = 0.
REQ-028 Reset asserted in any state SHALL discard the in-flight instruction; no bundle SHALL be emitted for it after release.

Structure
REQ-029 A shared package SHALL hold the shift_op enum (LSL/LSR/ASR/ROR), the FSM state enum, and the operand2 field-position constants.
REQ-030 The block SHALL be a single module with no sub-module; it drives the existing barrel shifter externally.

Verification
REQ-031 Immediate: instr[25]=1, rot=4, imm8=0xFF -> 1 cycle later out_valid=1, shift_in=0x000000FF, op=11, amt=8, rrx=0, rf_rd_en never 1.
REQ-032 Immediate shift: Rm=3, LSR #0, rf returns 0x80000001 -> rd_addr=3 in cycle 1; cycle 3: shift_in=0x80000001, op=01, amt=32; ROR #0 variant -> op=11, amt=1, rrx=1.
REQ-033 Register shift: Rm=2, Rs=5, ASR, rf returns 0x12345678 then 0xFFFFFF21 -> addresses 2 then 5; cycle 4: shift_in=0x12345678, op=10, amt=0x21.
REQ-034 Backpressure: out_ready=0 for 3 cycles in OUT -> outputs bit-identical each cycle; out_ready=1 with in_valid=1 -> second instruction accepted in the same cycle; its bundle follows at its own latency.
REQ-035 Reset mid-operation: rst_n=0 during CAP -> out_valid=0, rf_rd_en=0 immediately; after release, no stale bundle, in_ready=1.

Source files
------------

// File: rtl/shift_operand_decoder_pkg.sv
// Shared definitions for the shift operand decoder.
// Holds the barrel-shifter operation encoding, the decoder FSM state
// encoding, the operand2 field positions inside a data-processing
// instruction word, and the immediate-shift amount decode helper.
package shift_operand_decoder_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RM   = 3'd1,
    ST_RS   = 3'd2,
    ST_CAP  = 3'd3,
    ST_OUT  = 3'd4
  } state_e;

  // operand2 field positions
  localparam int unsigned OP2_IMM_BIT  = 25;
  localparam int unsigned ROT_MSB      = 11;
  localparam int unsigned ROT_LSB      = 8;
  localparam int unsigned IMM8_MSB     = 7;
  localparam int unsigned IMM8_LSB     = 0;
  localparam int unsigned SHAMT_MSB    = 11;
  localparam int unsigned SHAMT_LSB    = 7;
  localparam int unsigned SHTYPE_MSB   = 6;
  localparam int unsigned SHTYPE_LSB   = 5;
  localparam int unsigned REG_SHIFT_BIT = 4;
  localparam int unsigned RS_MSB       = 11;
  localparam int unsigned RS_LSB       = 8;
  localparam int unsigned RM_MSB       = 3;
  localparam int unsigned RM_LSB       = 0;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] amt;
    logic        rrx;
  } shift_fields_t;

  // A zero immediate shift amount is an alias: LSR/ASR #0 mean a full
  // 32-bit shift and ROR #0 means rotate-right-extended by one.
  function automatic shift_fields_t decode_imm_shift(input logic [1:0] op,
                                                     input logic [4:0] n);
    shift_fields_t f;
    f.op  = op;
    f.amt = {27'b0, n};
    f.rrx = 1'b0;
    if (n == 5'd0) begin
      case (op)
        SH_LSR, SH_ASR: f.amt = 32'd32;
        SH_ROR: begin
          f.amt = 32'd1;
          f.rrx = 1'b1;
        end
        default: f.amt = 32'd0;
      endcase
    end
    return f;
  endfunction

endpackage

// File: rtl/shift_operand_decoder.sv
// Shift operand decoder.
// Decodes operand2 of a data-processing instruction into a bundle for the
// external barrel shifter, fetching Rm and (optionally) Rs from the register
// file through a single read port with one-cycle read latency.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   in_valid/in_ready/instr instruction handshake
//   rf_rd_en/rf_rd_addr     register-file read request
//   rf_rd_data              read data, valid the cycle after rf_rd_en
//   out_valid/out_ready     operand bundle handshake
//   shift_in/shift_op/shift_amt/rrx  operand bundle
//
// state | meaning
// IDLE  | waiting for an instruction
// RM    | reading Rm
// RS    | capturing Rm data; reading Rs for register-specified shifts
// CAP   | capturing Rs[7:0] as the shift amount
// OUT   | bundle presented, held until out_ready
module shift_operand_decoder
  import shift_operand_decoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic        rf_rd_en,
  output logic [3:0]  rf_rd_addr,
  input  logic [31:0] rf_rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] shift_in,
  output logic [1:0]  shift_op,
  output logic [31:0] shift_amt,
  output logic        rrx
);

  state_e        state_q, state_d;
  logic [3:0]    rm_q, rm_d;
  logic [3:0]    rs_q, rs_d;
  logic          reg_shift_q, reg_shift_d;
  logic [31:0]   shift_in_q, shift_in_d;
  logic [1:0]    shift_op_q, shift_op_d;
  logic [31:0]   shift_amt_q, shift_amt_d;
  logic          rrx_q, rrx_d;
  logic          accept;
  shift_fields_t imm_fields;

  // Opcode, condition and destination fields belong to other decoders.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31:26], instr[24:12]};

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_OUT) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_OUT);

  assign imm_fields = decode_imm_shift(instr[SHTYPE_MSB:SHTYPE_LSB],
                                       instr[SHAMT_MSB:SHAMT_LSB]);

  always_comb begin
    state_d     = state_q;
    rm_d        = rm_q;
    rs_d        = rs_q;
    reg_shift_d = reg_shift_q;
    shift_in_d  = shift_in_q;
    shift_op_d  = shift_op_q;
    shift_amt_d = shift_amt_q;
    rrx_d       = rrx_q;
    rf_rd_en    = 1'b0;
    rf_rd_addr  = 4'd0;

    case (state_q)
      ST_RM: begin
        rf_rd_en   = 1'b1;
        rf_rd_addr = rm_q;
        state_d    = ST_RS;
      end
      ST_RS: begin
        shift_in_d = rf_rd_data;
        if (reg_shift_q) begin
          rf_rd_en   = 1'b1;
          rf_rd_addr = rs_q;
          state_d    = ST_CAP;
        end else begin
          state_d = ST_OUT;
        end
      end
      ST_CAP: begin
        shift_amt_d = {24'b0, rf_rd_data[7:0]};
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Accepting overrides the OUT->IDLE step so back-to-back issue works.
    if (accept) begin
      rm_d        = instr[RM_MSB:RM_LSB];
      rs_d        = instr[RS_MSB:RS_LSB];
      reg_shift_d = instr[REG_SHIFT_BIT];
      if (instr[OP2_IMM_BIT]) begin
        shift_in_d  = {24'b0, instr[IMM8_MSB:IMM8_LSB]};
        shift_op_d  = SH_ROR;
        shift_amt_d = {27'b0, instr[ROT_MSB:ROT_LSB], 1'b0};
        rrx_d       = 1'b0;
        state_d     = ST_OUT;
      end else begin
        // Register-shift amount arrives later in CAP; the type is known now.
        shift_op_d = instr[SHTYPE_MSB:SHTYPE_LSB];
        if (instr[REG_SHIFT_BIT]) begin
          shift_amt_d = 32'd0;
          rrx_d       = 1'b0;
        end else begin
          shift_op_d  = imm_fields.op;
          shift_amt_d = imm_fields.amt;
          rrx_d       = imm_fields.rrx;
        end
        state_d = ST_RM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rm_q        <= 4'd0;
      rs_q        <= 4'd0;
      reg_shift_q <= 1'b0;
      shift_in_q  <= 32'd0;
      shift_op_q  <= SH_LSL;
      shift_amt_q <= 32'd0;
      rrx_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rm_q        <= rm_d;
      rs_q        <= rs_d;
      reg_shift_q <= reg_shift_d;
      shift_in_q  <= shift_in_d;
      shift_op_q  <= shift_op_d;
      shift_amt_q <= shift_amt_d;
      rrx_q       <= rrx_d;
    end
  end

  assign shift_in  = shift_in_q;
  assign shift_op  = shift_op_q;
  assign shift_amt = shift_amt_q;
  assign rrx       = rrx_q;

endmodule
